uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin packet arbiter that shares one UART transmit path among `N_REQ` byte-stream requesters. It sits in front of the `uart` write interface (`i_wr_uart` / `i_wr_data` / `o_tx_full`). It grants one requester at a time for a whole packet and can prepend a source-ID header byte. A stall watchdog drops a requester that stops supplying bytes mid-packet.

## Interface
- `N_REQ`, 4: number of requesters, 2..16.
- `DBITS`, 8: byte width; must match the UART `DBITS`.
- `HDR_EN`, 1: 1 = emit a header byte before each packet; 0 = no header.
- `HDR_BASE`, 8'hA0: header value is `HDR_BASE + k` for requester k, modulo 2^DBITS.
- `TIMEOUT`, 1024: mid-packet stall limit in cycles; 0 disables the watchdog.

Ports:
- `i_clk` in 1: single clock. There is one clock.
- `i_rst` in 1: reset, synchronous and active-high.
- `i_valid` in N_REQ: per-requester byte valid.
- `i_last` in N_REQ: per-requester last-byte-of-packet flag; qualified by valid.
- `i_data` in N_REQ*DBITS: requester k occupies `[k*DBITS +: DBITS]`.
- `o_ready` out N_REQ: per-requester byte accepted this cycle when high together with valid.
- `i_tx_full` in 1: UART TX FIFO full.
- `o_wr_uart` out 1: write strobe to the UART TX FIFO.
- `o_wr_data` out DBITS: byte to write.
- `o_grant` out N_REQ: one-hot current owner; all zero when idle.
- `o_busy` out 1: packet in progress (state ≠ IDLE).
- `o_timeout` out 1: one-cycle pulse when a grant is aborted by the watchdog.

## Operation
- States: IDLE, HDR, DATA.
- **IDLE**
  - If any `i_valid` bit is set, select the first set requester searching upward (with wrap) from `last_grant+1`.
  - Register `grant` and set `last_grant <= grant`.
  - Go to HDR if `HDR_EN`, else DATA.
  - `o_ready = 0` and `o_wr_uart = 0` in IDLE.
- **HDR**
  - `o_wr_uart = !i_tx_full`, `o_wr_data = HDR_BASE + grant`.
  - When written, go to DATA. If `i_tx_full` is high, hold.
- **DATA**
  - `o_ready[g] = (g == grant) && !i_tx_full`. All other ready bits are 0.
  - `o_wr_uart = i_valid[grant] & o_ready[grant]`; `o_wr_data` is the granted requester's slice.
  - On a write with `i_last[grant]` set, go to IDLE and clear `o_grant`.
- **Watchdog** (only when `TIMEOUT != 0`)
  - In DATA, the counter increments on each cycle with `!i_valid[grant]`.
  - It clears on every accepted byte and on entry to DATA.
  - Cycles stalled by `i_tx_full` while valid is high do not count.
  - When the counter reaches TIMEOUT: pulse `o_timeout`, go to IDLE, and emit no further bytes for that packet. No filler is inserted.
- Requests that are not granted are never acknowledged. Requesters hold data and valid until ready.
- A byte presented while `i_tx_full=1` is not accepted and not written.

## Timing
- Reset values: state IDLE, `o_grant=0`, `o_busy=0`, `o_timeout=0`, `o_wr_uart=0`, `o_ready=0`, watchdog counter 0, `last_grant=N_REQ-1` (so requester 0 has first priority).
- `o_ready`, `o_wr_uart` and `o_wr_data` are combinational from state/grant registers, `i_valid` and `i_tx_full`. No register sits in the data path, so there is 0-cycle latency from handshake to FIFO write.
- Request to first write: 1 IDLE cycle (arbitration), then the header or data write in the next cycle.
- There is a minimum of 1 IDLE cycle between packets. The last-byte cycle and the next arbitration never overlap.
- Single-byte packet (valid+last on the first DATA cycle) is legal.
- Reset mid-packet: the next cycle is IDLE with no write, and the partial packet is abandoned.
- Watchdog counter width is `$clog2(TIMEOUT+1)`. The abort fires on the cycle the count equals TIMEOUT. That is TIMEOUT consecutive no-valid cycles after the last accept.

## Structure
- Package `uart_arb_pkg` holds:
  - the state encoding (IDLE=2'd0, HDR=2'd1, DATA=2'd2);
  - the default `HDR_BASE`;
  - a `clog2`-based counter-width constant function.
- One sub-module, `rr_arbiter`, is natural. It is purely combinational: inputs are the request vector and `last_grant`, output is the one-hot grant. The FSM, watchdog and datapath mux stay in `uart_tx_arbiter`.

## Test plan
- **Round-robin:** `N_REQ=4`, `HDR_EN=1`, all four requesters each hold a 2-byte packet, `i_tx_full=0` → FIFO sees A0,d0a,d0b, A1,…, A3,… in order 0,1,2,3, with one idle cycle between packets.
- **Fairness:** after requester 2 finishes, requesters 1 and 3 both request → requester 3 is granted first, then 1.
- **Backpressure:** `i_tx_full=1` for 5 cycles during DATA → no `o_wr_uart` and `o_ready[g]=0` in those cycles. No watchdog count while valid is high. The byte is written on the first cycle full drops.
- **Watchdog:** `TIMEOUT=8`, requester 1 sends 1 byte then drops valid → `o_timeout` pulses exactly 8 cycles after the accept, state returns to IDLE, and the next pending requester is granted.
- **`HDR_EN=0`, single-byte packets:** each packet yields exactly one FIFO write equal to the requester's data.
- **Reset mid-packet:** `i_rst` asserted during DATA → next cycle `o_grant=0`, `o_busy=0`, `o_wr_uart=0`. After release, requester 0 has priority.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_DATA = 2'd2
    } state_e;

    localparam logic [7:0] HDR_BASE_DEF = 8'hA0;

    // Stall counter width; never below 1 bit so a disabled watchdog still elaborates.
    function automatic int cnt_w(input int t);
        return (t < 1) ? 1 : $clog2(t + 1);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams plus the UART TX FIFO write port.
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int DBITS = 8
);
    logic [N_REQ-1:0]       i_valid;
    logic [N_REQ-1:0]       i_last;
    logic [N_REQ*DBITS-1:0] i_data;
    logic [N_REQ-1:0]       o_ready;
    logic                   i_tx_full;
    logic                   o_wr_uart;
    logic [DBITS-1:0]       o_wr_data;

    modport master (
        output i_valid, i_last, i_data, i_tx_full,
        input  o_ready, o_wr_uart, o_wr_data
    );

    modport slave (
        input  i_valid, i_last, i_data, i_tx_full,
        output o_ready, o_wr_uart, o_wr_data
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first request searching upward from last_i+1, with wrap.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] last_i,
    output logic [N-1:0]         gnt_o
);
    int   idx;
    logic found;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= N; i++) begin
            idx = (int'(last_i) + i) % N;
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter in front of a UART TX FIFO, with optional
// source-ID header byte and a mid-packet stall watchdog.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int               N_REQ    = 4,
    parameter int               DBITS    = 8,
    parameter int               HDR_EN   = 1,
    parameter logic [DBITS-1:0] HDR_BASE = DBITS'(HDR_BASE_DEF),
    parameter int               TIMEOUT  = 1024
) (
    input  logic               i_clk,
    input  logic               i_rst,
    uart_tx_arbiter_if.slave   bus,
    output logic [N_REQ-1:0]   o_grant,
    output logic               o_busy,
    output logic               o_timeout
);
    localparam int             IW      = $clog2(N_REQ);
    localparam int             CW      = cnt_w(TIMEOUT);
    localparam logic [CW-1:0]  TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_e           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]    last_q, last_d;
    logic [CW-1:0]    wd_q, wd_d;

    logic [N_REQ-1:0] arb_gnt;
    logic [IW-1:0]    gidx;
    logic             cur_valid, cur_last, acc, wd_hit;
    logic [DBITS-1:0] cur_data;

    logic [N_REQ-1:0] ready;
    logic             wr;
    logic [DBITS-1:0] wr_data;

    function automatic logic [IW-1:0] enc(input logic [N_REQ-1:0] v);
        logic [IW-1:0] r;
        r = '0;
        for (int i = 0; i < N_REQ; i++)
            if (v[i]) r = IW'(i);
        return r;
    endfunction

    rr_arbiter #(.N(N_REQ)) u_rr (
        .req_i  (bus.i_valid),
        .last_i (last_q),
        .gnt_o  (arb_gnt)
    );

    assign gidx      = enc(gnt_q);
    assign cur_valid = bus.i_valid[gidx];
    assign cur_last  = bus.i_last[gidx];
    assign cur_data  = bus.i_data[gidx*DBITS +: DBITS];
    assign acc       = (state_q == S_DATA) && cur_valid && !bus.i_tx_full;
    // Fires on the TIMEOUT-th consecutive no-valid cycle after the last accept.
    assign wd_hit    = (TIMEOUT != 0) && (state_q == S_DATA) && !cur_valid && (wd_q == TO_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            last_q  <= IW'(N_REQ - 1);
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            wd_q    <= wd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        wd_d    = '0;
        case (state_q)
            S_IDLE: begin
                if (|bus.i_valid) begin
                    gnt_d   = arb_gnt;
                    last_d  = enc(arb_gnt);
                    state_d = (HDR_EN != 0) ? S_HDR : S_DATA;
                end
            end
            S_HDR: begin
                if (!bus.i_tx_full) state_d = S_DATA;
            end
            S_DATA: begin
                // Backpressured cycles with valid high hold the count.
                if (TIMEOUT == 0 || acc) wd_d = '0;
                else if (!cur_valid)     wd_d = wd_q + CW'(1);
                else                     wd_d = wd_q;
                if ((acc && cur_last) || wd_hit) begin
                    state_d = S_IDLE;
                    gnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        ready   = '0;
        wr      = 1'b0;
        wr_data = cur_data;
        case (state_q)
            S_HDR: begin
                wr      = !bus.i_tx_full;
                wr_data = HDR_BASE + DBITS'(gidx);
            end
            S_DATA: begin
                ready = bus.i_tx_full ? '0 : gnt_q;
                wr    = acc;
            end
            default: ;
        endcase
    end

    assign bus.o_ready   = ready;
    assign bus.o_wr_uart = wr;
    assign bus.o_wr_data = wr_data;
    assign o_grant       = gnt_q;
    assign o_busy        = (state_q != S_IDLE);
    assign o_timeout     = wd_hit;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench: header/RR ordering, fairness, backpressure, watchdog, no-header mode, reset mid-packet.
module tb_uart_tx_arbiter;
    logic i_clk = 1'b0;
    logic i_rst;
    always #5 i_clk = ~i_clk;

    uart_tx_arbiter_if #(.N_REQ(4), .DBITS(8)) bus_a ();
    uart_tx_arbiter_if #(.N_REQ(4), .DBITS(8)) bus_b ();

    logic [3:0] gnt_a, gnt_b;
    logic       busy_a, busy_b, to_a, to_b;

    uart_tx_arbiter #(.N_REQ(4), .DBITS(8), .HDR_EN(1), .HDR_BASE(8'hA0), .TIMEOUT(8)) dut_a (
        .i_clk(i_clk), .i_rst(i_rst), .bus(bus_a),
        .o_grant(gnt_a), .o_busy(busy_a), .o_timeout(to_a)
    );

    uart_tx_arbiter #(.N_REQ(4), .DBITS(8), .HDR_EN(0), .HDR_BASE(8'hA0), .TIMEOUT(0)) dut_b (
        .i_clk(i_clk), .i_rst(i_rst), .bus(bus_b),
        .o_grant(gnt_b), .o_busy(busy_b), .o_timeout(to_b)
    );

    // Per-requester packet queues: {last, data}.
    logic [8:0] mem_a [4][32];
    logic [8:0] mem_b [4][32];
    int hd_a [4], tl_a [4], hd_b [4], tl_b [4];
    logic [7:0] wlog_a [$], wlog_b [$];
    int wcyc_a [$], wcyc_b [$];
    int cycle, total, bad;

    task automatic push_a(input int k, input logic [7:0] d, input logic l);
        mem_a[k][tl_a[k]] = {l, d};
        tl_a[k]++;
    endtask

    task automatic push_b(input int k, input logic [7:0] d, input logic l);
        mem_b[k][tl_b[k]] = {l, d};
        tl_b[k]++;
    endtask

    task automatic clear_all();
        for (int k = 0; k < 4; k++) begin
            hd_a[k] = 0; tl_a[k] = 0; hd_b[k] = 0; tl_b[k] = 0;
        end
        wlog_a.delete(); wcyc_a.delete(); wlog_b.delete(); wcyc_b.delete();
    endtask

    task automatic apply();
        logic [3:0]  va, la, vb, lb;
        logic [31:0] da, db;
        va = '0; la = '0; vb = '0; lb = '0; da = '0; db = '0;
        for (int k = 0; k < 4; k++) begin
            if (hd_a[k] < tl_a[k]) begin
                va[k] = 1'b1; la[k] = mem_a[k][hd_a[k]][8]; da[k*8 +: 8] = mem_a[k][hd_a[k]][7:0];
            end
            if (hd_b[k] < tl_b[k]) begin
                vb[k] = 1'b1; lb[k] = mem_b[k][hd_b[k]][8]; db[k*8 +: 8] = mem_b[k][hd_b[k]][7:0];
            end
        end
        bus_a.i_valid = va; bus_a.i_last = la; bus_a.i_data = da;
        bus_b.i_valid = vb; bus_b.i_last = lb; bus_b.i_data = db;
        #1;
    endtask

    // Record handshakes/writes of the current window, cross the edge, then drive next heads.
    task automatic cyc();
        logic [3:0] acc_a, acc_b;
        acc_a = bus_a.i_valid & bus_a.o_ready;
        acc_b = bus_b.i_valid & bus_b.o_ready;
        if (bus_a.o_wr_uart) begin wlog_a.push_back(bus_a.o_wr_data); wcyc_a.push_back(cycle); end
        if (bus_b.o_wr_uart) begin wlog_b.push_back(bus_b.o_wr_data); wcyc_b.push_back(cycle); end
        @(posedge i_clk);
        #1;
        cycle++;
        for (int k = 0; k < 4; k++) begin
            if (acc_a[k]) hd_a[k]++;
            if (acc_b[k]) hd_b[k]++;
        end
        apply();
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        bus_a.i_tx_full = 1'b0;
        bus_b.i_tx_full = 1'b0;
        clear_all();
        apply();
        cyc(); cyc();
        i_rst = 1'b0;
        cyc();
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL rst_busy got=%h exp=0", busy_a); end
        total++; if (gnt_a !== 4'b0) begin bad++; $display("FAIL rst_grant got=%h exp=0", gnt_a); end
        total++; if (to_a !== 1'b0) begin bad++; $display("FAIL rst_timeout got=%h exp=0", to_a); end
        total++; if (bus_a.o_wr_uart !== 1'b0) begin bad++; $display("FAIL rst_wr got=%h exp=0", bus_a.o_wr_uart); end
        total++; if (bus_a.o_ready !== 4'b0) begin bad++; $display("FAIL rst_ready got=%h exp=0", bus_a.o_ready); end
        total++; if ({busy_b, gnt_b, to_b} !== 6'b0) begin bad++; $display("FAIL rst_b got=%h exp=0", {busy_b, gnt_b, to_b}); end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_rr [12];
        int w0;
        exp_rr = '{8'hA0, 8'h10, 8'h11, 8'hA1, 8'h12, 8'h13, 8'hA2, 8'h14, 8'h15, 8'hA3, 8'h16, 8'h17};
        clear_all();
        for (int k = 0; k < 4; k++) begin
            push_a(k, 8'(8'h10 + 2*k), 1'b0);
            push_a(k, 8'(8'h11 + 2*k), 1'b1);
        end
        apply();
        w0 = cycle;
        for (int n = 0; n < 80 && wlog_a.size() < 12; n++) cyc();
        total++; if (wlog_a.size() != 12) begin bad++; $display("FAIL rr_count got=%0d exp=12", wlog_a.size()); end
        if (wlog_a.size() == 12) begin
            for (int i = 0; i < 12; i++) begin
                total++;
                if (wlog_a[i] !== exp_rr[i]) begin bad++; $display("FAIL rr_byte%0d got=%h exp=%h", i, wlog_a[i], exp_rr[i]); end
            end
            total++; if (wcyc_a[0] != w0 + 1) begin bad++; $display("FAIL rr_latency got=%0d exp=%0d", wcyc_a[0], w0 + 1); end
            for (int k = 0; k < 3; k++) begin
                total++;
                if (wcyc_a[3*k+3] - wcyc_a[3*k+2] != 2) begin
                    bad++; $display("FAIL rr_gap%0d got=%0d exp=2", k, wcyc_a[3*k+3] - wcyc_a[3*k+2]);
                end
            end
        end
    endtask

    task automatic test_fairness();
        logic [7:0] exp_f [6];
        exp_f = '{8'hA2, 8'h22, 8'hA3, 8'h33, 8'hA1, 8'h31};
        clear_all();
        push_a(2, 8'h22, 1'b1);
        apply();
        cyc();
        push_a(1, 8'h31, 1'b1);
        push_a(3, 8'h33, 1'b1);
        apply();
        total++; if (gnt_a !== 4'b0100) begin bad++; $display("FAIL fair_hold got=%h exp=4", gnt_a); end
        total++; if (bus_a.o_ready !== 4'b0) begin bad++; $display("FAIL fair_hdr_ready got=%h exp=0", bus_a.o_ready); end
        cyc();
        total++; if (bus_a.o_ready !== 4'b0100) begin bad++; $display("FAIL fair_data_ready got=%h exp=4", bus_a.o_ready); end
        for (int n = 0; n < 40 && wlog_a.size() < 6; n++) cyc();
        total++; if (wlog_a.size() != 6) begin bad++; $display("FAIL fair_count got=%0d exp=6", wlog_a.size()); end
        if (wlog_a.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                total++;
                if (wlog_a[i] !== exp_f[i]) begin bad++; $display("FAIL fair_byte%0d got=%h exp=%h", i, wlog_a[i], exp_f[i]); end
            end
        end
    endtask

    task automatic test_backpressure();
        clear_all();
        push_a(0, 8'h50, 1'b0);
        push_a(0, 8'h51, 1'b1);
        apply();
        cyc();
        total++; if ({bus_a.o_wr_uart, bus_a.o_wr_data} !== 9'h1A0) begin
            bad++; $display("FAIL bp_hdr got=%h exp=1a0", {bus_a.o_wr_uart, bus_a.o_wr_data}); end
        cyc();
        bus_a.i_tx_full = 1'b1;
        apply();
        // Stall longer than TIMEOUT: the watchdog must not count while valid is high.
        for (int i = 0; i < 10; i++) begin
            total++; if (bus_a.o_wr_uart !== 1'b0) begin bad++; $display("FAIL bp_wr%0d got=%h exp=0", i, bus_a.o_wr_uart); end
            total++; if (bus_a.o_ready !== 4'b0) begin bad++; $display("FAIL bp_ready%0d got=%h exp=0", i, bus_a.o_ready); end
            total++; if (to_a !== 1'b0) begin bad++; $display("FAIL bp_to%0d got=%h exp=0", i, to_a); end
            cyc();
        end
        bus_a.i_tx_full = 1'b0;
        apply();
        total++; if ({bus_a.o_wr_uart, bus_a.o_wr_data} !== 9'h150) begin
            bad++; $display("FAIL bp_release got=%h exp=150", {bus_a.o_wr_uart, bus_a.o_wr_data}); end
        total++; if (bus_a.o_ready !== 4'b0001) begin bad++; $display("FAIL bp_rel_ready got=%h exp=1", bus_a.o_ready); end
        total++; if (gnt_a !== 4'b0001) begin bad++; $display("FAIL bp_grant got=%h exp=1", gnt_a); end
        cyc();
        total++; if ({bus_a.o_wr_uart, bus_a.o_wr_data} !== 9'h151) begin
            bad++; $display("FAIL bp_last got=%h exp=151", {bus_a.o_wr_uart, bus_a.o_wr_data}); end
        cyc();
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL bp_idle got=%h exp=0", busy_a); end
    endtask

    task automatic test_watchdog();
        clear_all();
        push_a(1, 8'h61, 1'b0);
        push_a(2, 8'h62, 1'b1);
        apply();
        cyc();
        total++; if (bus_a.o_wr_data !== 8'hA1) begin bad++; $display("FAIL wd_hdr got=%h exp=a1", bus_a.o_wr_data); end
        cyc();
        total++; if ({bus_a.o_wr_uart, bus_a.o_wr_data} !== 9'h161) begin
            bad++; $display("FAIL wd_accept got=%h exp=161", {bus_a.o_wr_uart, bus_a.o_wr_data}); end
        for (int i = 1; i <= 8; i++) begin
            cyc();
            total++; if (to_a !== (i == 8)) begin bad++; $display("FAIL wd_pulse%0d got=%h exp=%h", i, to_a, (i == 8)); end
            total++; if (bus_a.o_wr_uart !== 1'b0) begin bad++; $display("FAIL wd_nowr%0d got=%h exp=0", i, bus_a.o_wr_uart); end
        end
        cyc();
        total++; if ({busy_a, to_a, bus_a.o_wr_uart} !== 3'b000) begin
            bad++; $display("FAIL wd_idle got=%b exp=000", {busy_a, to_a, bus_a.o_wr_uart}); end
        cyc();
        total++; if (gnt_a !== 4'b0100) begin bad++; $display("FAIL wd_next_grant got=%h exp=4", gnt_a); end
        total++; if (bus_a.o_wr_data !== 8'hA2) begin bad++; $display("FAIL wd_next_hdr got=%h exp=a2", bus_a.o_wr_data); end
        cyc();
        total++; if ({bus_a.o_wr_uart, bus_a.o_wr_data} !== 9'h162) begin
            bad++; $display("FAIL wd_next_data got=%h exp=162", {bus_a.o_wr_uart, bus_a.o_wr_data}); end
        cyc();
    endtask

    task automatic test_no_hdr();
        logic [7:0] exp_b [3];
        int w0;
        exp_b = '{8'h70, 8'h72, 8'h73};
        clear_all();
        push_b(0, 8'h70, 1'b1);
        push_b(2, 8'h72, 1'b1);
        push_b(3, 8'h73, 1'b1);
        apply();
        w0 = cycle;
        for (int n = 0; n < 30 && wlog_b.size() < 3; n++) cyc();
        repeat (4) cyc();
        total++; if (wlog_b.size() != 3) begin bad++; $display("FAIL nohdr_count got=%0d exp=3", wlog_b.size()); end
        if (wlog_b.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (wlog_b[i] !== exp_b[i]) begin bad++; $display("FAIL nohdr_byte%0d got=%h exp=%h", i, wlog_b[i], exp_b[i]); end
                total++;
                if (wcyc_b[i] != w0 + 1 + 2*i) begin bad++; $display("FAIL nohdr_cyc%0d got=%0d exp=%0d", i, wcyc_b[i], w0 + 1 + 2*i); end
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_all();
        push_a(3, 8'h80, 1'b0);
        push_a(3, 8'h81, 1'b0);
        push_a(3, 8'h82, 1'b1);
        push_a(0, 8'h90, 1'b1);
        apply();
        cyc();
        total++; if (gnt_a !== 4'b1000) begin bad++; $display("FAIL rm_grant3 got=%h exp=8", gnt_a); end
        cyc();
        i_rst = 1'b1;
        cyc();
        total++; if ({gnt_a, busy_a, bus_a.o_wr_uart} !== 6'b0) begin
            bad++; $display("FAIL rm_reset got=%b exp=000000", {gnt_a, busy_a, bus_a.o_wr_uart}); end
        i_rst = 1'b0;
        cyc();
        total++; if (gnt_a !== 4'b0001) begin bad++; $display("FAIL rm_prio got=%h exp=1", gnt_a); end
        total++; if (bus_a.o_wr_data !== 8'hA0) begin bad++; $display("FAIL rm_hdr got=%h exp=a0", bus_a.o_wr_data); end
        cyc();
        total++; if ({bus_a.o_wr_uart, bus_a.o_wr_data} !== 9'h190) begin
            bad++; $display("FAIL rm_data got=%h exp=190", {bus_a.o_wr_uart, bus_a.o_wr_data}); end
        cyc();
        clear_all();
        apply();
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL rm_idle got=%h exp=0", busy_a); end
    endtask

    initial begin
        cycle = 0; total = 0; bad = 0;
        test_reset();
        test_round_robin();
        test_fairness();
        test_backpressure();
        test_watchdog();
        test_no_hdr();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
